// File: rtl/tiempos_pkg.sv
// Shared types and limits for the 1 Hz event timer and its uptime clock.
package tiempos_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } estado_t;

    localparam logic [5:0] SEG_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    function automatic logic [5:0] siguiente_mod(input logic [5:0] valor, input logic [5:0] maximo);
        return (valor == maximo) ? 6'd0 : valor + 6'd1;
    endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Multi-flop synchronizer for an asynchronous level followed by a rising-edge
// detector; emits a one-cycle tick per rising edge of the input.
module sincronizador_flanco #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dato_i,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dato_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/temporizador_eventos.sv
// 1 Hz consumer: free-running mm:ss uptime plus a programmable countdown that
// emits one-cycle event pulses, all clocked in the clk_50MHz domain.
module temporizador_eventos
    import tiempos_pkg::*;
#(
    parameter int unsigned PERIOD_W    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    input  logic                clk_1Hz,
    input  logic                start,
    input  logic                stop,
    input  logic                pausa,
    input  logic                load,
    input  logic [PERIOD_W-1:0] periodo,
    output logic [5:0]          seg,
    output logic [5:0]          min,
    output logic                vuelta,
    output logic                evento,
    output logic [PERIOD_W-1:0] restante,
    output logic                activo
);

    logic tick;

    sincronizador_flanco #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sinc (
        .clk    (clk_50MHz),
        .rst_n  (reset),
        .dato_i (clk_1Hz),
        .tick   (tick)
    );

    logic [5:0]          seg_q, seg_d;
    logic [5:0]          min_q, min_d;
    logic                vuelta_q, vuelta_d;
    estado_t             estado_q, estado_d;
    logic [PERIOD_W-1:0] restante_q, restante_d;
    logic                evento_q, evento_d;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            seg_q      <= '0;
            min_q      <= '0;
            vuelta_q   <= 1'b0;
            estado_q   <= IDLE;
            restante_q <= '0;
            evento_q   <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            min_q      <= min_d;
            vuelta_q   <= vuelta_d;
            estado_q   <= estado_d;
            restante_q <= restante_d;
            evento_q   <= evento_d;
        end
    end

    always_comb begin
        seg_d    = seg_q;
        min_d    = min_q;
        vuelta_d = 1'b0;
        if (tick) begin
            seg_d = siguiente_mod(seg_q, SEG_MAX);
            if (seg_q == SEG_MAX) begin
                min_d    = siguiente_mod(min_q, MIN_MAX);
                vuelta_d = (min_q == MIN_MAX);
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        restante_d = restante_q;
        evento_d   = 1'b0;
        case (estado_q)
            IDLE: begin
                if (!stop && start && (periodo != '0)) begin
                    estado_d   = RUN;
                    restante_d = periodo;
                end
            end
            RUN, PAUSED: begin
                if (stop) begin
                    estado_d   = IDLE;
                    restante_d = '0;
                end else if (load) begin
                    restante_d = periodo;
                    if (periodo == '0) begin
                        estado_d = IDLE;
                    end
                end else begin
                    // The pausa level gates the countdown directly, so a tick
                    // landing on a RUN/PAUSED transition cycle is neither lost nor replayed.
                    estado_d = pausa ? PAUSED : RUN;
                    if (tick && !pausa) begin
                        if (restante_q == PERIOD_W'(1)) begin
                            evento_d   = 1'b1;
                            restante_d = periodo;
                            if (periodo == '0) begin
                                estado_d = IDLE;
                            end
                        end else if (restante_q != '0) begin
                            restante_d = restante_q - PERIOD_W'(1);
                        end
                    end
                end
            end
            default: begin
                estado_d   = IDLE;
                restante_d = '0;
            end
        endcase
    end

    assign seg      = seg_q;
    assign min      = min_q;
    assign vuelta   = vuelta_q;
    assign evento   = evento_q;
    assign restante = restante_q;
    assign activo   = (estado_q != IDLE);

endmodule

// File: tb/tb_temporizador_eventos.sv
// Directed bench for temporizador_eventos: table of strobe/tick steps with
// hand-computed results, plus sequences for latency, collision, reset and wrap.
module tb_temporizador_eventos;

    logic       clk_50MHz = 1'b0;
    logic       reset     = 1'b0;
    logic       clk_1Hz   = 1'b0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic       pausa     = 1'b0;
    logic       load      = 1'b0;
    logic [7:0] periodo   = 8'd0;
    logic [5:0] seg, min;
    logic       vuelta, evento, activo;
    logic [7:0] restante;

    temporizador_eventos #(
        .PERIOD_W    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .clk_1Hz   (clk_1Hz),
        .start     (start),
        .stop      (stop),
        .pausa     (pausa),
        .load      (load),
        .periodo   (periodo),
        .seg       (seg),
        .min       (min),
        .vuelta    (vuelta),
        .evento    (evento),
        .restante  (restante),
        .activo    (activo)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int n_tests = 0;
    int n_fail  = 0;
    int up      = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       load;
        logic       pausa;
        logic       tick;
        logic [7:0] periodo;
        logic       exp_activo;
        logic [7:0] exp_rest;
        int         exp_ev;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic ld, input logic pa,
                       input logic tk, input int per, input logic ea, input int er, input int ee);
        vec_t v;
        v.start = st; v.stop = sp; v.load = ld; v.pausa = pa; v.tick = tk;
        v.periodo = 8'(per); v.exp_activo = ea; v.exp_rest = 8'(er); v.exp_ev = ee;
        vecs.push_back(v);
    endtask

    // One clk_1Hz pulse, 4 cycles high and 4 low; counts cycles evento/vuelta are high.
    task automatic do_tick(output int ev, output int vu);
        ev = 0; vu = 0;
        clk_1Hz = 1'b1;
        repeat (4) begin
            @(negedge clk_50MHz);
            ev += int'(evento); vu += int'(vuelta);
        end
        clk_1Hz = 1'b0;
        repeat (4) begin
            @(negedge clk_50MHz);
            ev += int'(evento); vu += int'(vuelta);
        end
    endtask

    task automatic strobe(input logic st, input logic sp, input logic ld);
        start = st; stop = sp; load = ld;
        @(negedge clk_50MHz);
        start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    initial begin
        int ev, vu, vu_tot;

        // Reset held: edges on clk_1Hz must not move anything.
        @(negedge clk_50MHz);
        for (int i = 0; i < 5; i++) do_tick(ev, vu);
        chk("rst_seg", seg, 0);
        chk("rst_min", min, 0);
        chk("rst_rest", restante, 0);
        chk("rst_evento", evento, 0);
        chk("rst_vuelta", vuelta, 0);
        chk("rst_activo", activo, 0);

        // First edge after release: seg moves exactly 2 cycles after sampling.
        reset = 1'b1;
        @(negedge clk_50MHz);
        clk_1Hz = 1'b1;
        @(negedge clk_50MHz);
        chk("lat_k", seg, 0);
        @(negedge clk_50MHz);
        chk("lat_k1", seg, 0);
        @(negedge clk_50MHz);
        chk("lat_k2", seg, 1);
        @(negedge clk_50MHz);
        clk_1Hz = 1'b0;
        repeat (4) @(negedge clk_50MHz);
        up = 1;

        // st sp ld pa tk per   act rest ev
        add(1, 0, 0, 0, 0, 3,   1, 3, 0);
        add(0, 0, 0, 0, 1, 3,   1, 2, 0);
        add(0, 0, 0, 0, 1, 3,   1, 1, 0);
        add(0, 0, 0, 0, 1, 3,   1, 3, 1);
        add(0, 0, 0, 0, 1, 3,   1, 2, 0);
        add(0, 0, 0, 0, 1, 3,   1, 1, 0);
        add(0, 0, 0, 0, 1, 3,   1, 3, 1);
        add(0, 0, 0, 0, 1, 3,   1, 2, 0);
        add(0, 0, 0, 0, 1, 3,   1, 1, 0);
        add(0, 0, 0, 0, 1, 3,   1, 3, 1);
        add(0, 1, 0, 0, 0, 3,   0, 0, 0);
        add(1, 0, 0, 0, 0, 0,   0, 0, 0);
        add(1, 0, 0, 0, 0, 4,   1, 4, 0);
        add(0, 0, 0, 0, 1, 4,   1, 3, 0);
        add(0, 0, 0, 0, 1, 4,   1, 2, 0);
        add(0, 0, 0, 1, 0, 4,   1, 2, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 4, 1, 2, 0);
        add(0, 0, 0, 0, 1, 4,   1, 1, 0);
        add(0, 0, 0, 0, 1, 4,   1, 4, 1);
        add(0, 1, 0, 0, 0, 4,   0, 0, 0);
        add(1, 1, 0, 0, 0, 4,   0, 0, 0);
        add(1, 0, 0, 0, 0, 2,   1, 2, 0);
        add(0, 0, 1, 0, 0, 7,   1, 7, 0);
        add(0, 0, 1, 0, 0, 0,   0, 0, 0);
        add(0, 0, 1, 0, 0, 5,   0, 0, 0);
        add(1, 0, 0, 0, 0, 3,   1, 3, 0);
        add(1, 0, 0, 0, 0, 9,   1, 3, 0);
        add(0, 0, 0, 0, 1, 0,   1, 2, 0);
        add(0, 0, 0, 0, 1, 0,   1, 1, 0);
        add(0, 0, 0, 0, 1, 0,   0, 0, 1);

        foreach (vecs[i]) begin
            pausa   = vecs[i].pausa;
            periodo = vecs[i].periodo;
            ev = 0;
            if (vecs[i].start || vecs[i].stop || vecs[i].load)
                strobe(vecs[i].start, vecs[i].stop, vecs[i].load);
            if (vecs[i].tick) begin
                do_tick(ev, vu);
                up++;
            end else begin
                repeat (2) @(negedge clk_50MHz);
            end
            chk($sformatf("v%0d_activo", i), activo, vecs[i].exp_activo);
            chk($sformatf("v%0d_rest", i), restante, vecs[i].exp_rest);
            chk($sformatf("v%0d_evento", i), ev, vecs[i].exp_ev);
            chk($sformatf("v%0d_seg", i), seg, up % 60);
        end
        pausa = 1'b0;

        // load coincides with a tick while restante=1: load wins, uptime still advances.
        periodo = 8'd2;
        strobe(1, 0, 0);
        do_tick(ev, vu);
        up++;
        chk("col_pre_rest", restante, 1);
        periodo = 8'd5;
        clk_1Hz = 1'b1;
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        load = 1'b1;
        @(negedge clk_50MHz);
        load = 1'b0;
        up++;
        chk("col_rest", restante, 5);
        chk("col_seg", seg, up % 60);
        ev = int'(evento);
        @(negedge clk_50MHz);
        clk_1Hz = 1'b0;
        repeat (4) begin
            @(negedge clk_50MHz);
            ev += int'(evento);
        end
        chk("col_evento", ev, 0);
        chk("col_activo", activo, 1);

        // Mid-run reset clears everything without waiting for a clock edge.
        strobe(0, 1, 0);
        periodo = 8'd4;
        strobe(1, 0, 0);
        do_tick(ev, vu);
        do_tick(ev, vu);
        chk("mrst_pre_rest", restante, 2);
        #5;
        reset = 1'b0;
        #1;
        chk("mrst_rest", restante, 0);
        chk("mrst_seg", seg, 0);
        chk("mrst_activo", activo, 0);
        chk("mrst_evento", evento, 0);
        @(negedge clk_50MHz);
        reset = 1'b1;
        @(negedge clk_50MHz);

        // Uptime wrap at 59:59.
        vu_tot = 0;
        for (int i = 0; i < 3599; i++) begin
            do_tick(ev, vu);
            vu_tot += vu;
        end
        chk("wrap_pre_seg", seg, 59);
        chk("wrap_pre_min", min, 59);
        chk("wrap_pre_vuelta", vu_tot, 0);
        do_tick(ev, vu);
        chk("wrap_seg", seg, 0);
        chk("wrap_min", min, 0);
        chk("wrap_vuelta_cycles", vu, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
